// File: rtl/dram_fifo64_reader.sv
// ---------------------------------------------------------------------------
// dram_fifo64_reader
//
// First-word-fall-through FIFO built on a 64-entry LUT-RAM store
// (synchronous write, asynchronous read) with a registered valid/ready
// output stage. Total capacity is 65 words: 64 in RAM plus 1 in the
// output register.
//
// Handshake: RD_DATA is a transfer when RD_VALID=1 and RD_READY=1 on the
// same rising edge. While RD_VALID=1 and RD_READY=0, RD_VALID and RD_DATA
// are held unchanged. A write is accepted on a rising edge when WR_EN=1
// and FULL=0; nothing else gates it.
//
// Parameters
//   WIDTH        data word width (1..64)
//   AF_LEVEL     ALMOST_FULL threshold on RAM occupancy (1..64)
//
// Ports
//   CLK          clock, rising edge
//   RST_N        asynchronous active-low reset
//   WR_EN        write request
//   WR_DATA      write word
//   FULL         RAM occupancy == 64 (registered)
//   ALMOST_FULL  RAM occupancy >= AF_LEVEL (registered)
//   OVERFLOW     sticky: a write was attempted while FULL=1
//   RD_VALID     RD_DATA holds a valid head word
//   RD_READY     downstream accepts RD_DATA
//   RD_DATA      head word (registered)
//   LEVEL        [6:0] words held = RAM occupancy + RD_VALID, only when
//                the macro DRAM_FIFO_LEVEL_EN is defined
//
// Configuration macro: DRAM_FIFO_LEVEL_EN (adds the LEVEL output).
// ---------------------------------------------------------------------------
module dram_fifo64_reader #(
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 48
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             FULL,
    output logic             ALMOST_FULL,
    output logic             OVERFLOW,
    output logic             RD_VALID,
    input  logic             RD_READY,
    output logic [WIDTH-1:0] RD_DATA
`ifdef DRAM_FIFO_LEVEL_EN
    ,
    output logic [6:0]       LEVEL
`endif
);

    logic [WIDTH-1:0] mem [0:63];
    logic [5:0]       wr_ptr;
    logic [5:0]       rd_ptr;
    logic [6:0]       ram_cnt;
    logic [6:0]       ram_cnt_nxt;
    logic             wr_acc;
    logic             ld;
    logic             rd_valid_nxt;

    // FULL is the registered flag, so a load in the same cycle never frees
    // a slot for a write that arrives while FULL=1.
    assign wr_acc = WR_EN & ~FULL;

    // Refill the output register when it is empty or being drained.
    assign ld = (ram_cnt != 7'd0) & (~RD_VALID | RD_READY);

    assign ram_cnt_nxt = ram_cnt + {6'd0, wr_acc} - {6'd0, ld};

    always_comb begin
        rd_valid_nxt = RD_VALID;
        if (ld) begin
            rd_valid_nxt = 1'b1;
        end else if (RD_VALID & RD_READY) begin
            rd_valid_nxt = 1'b0;
        end
    end

    // Storage has no reset, matching LUT-RAM primitives.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr      <= 6'd0;
            rd_ptr      <= 6'd0;
            ram_cnt     <= 7'd0;
            FULL        <= 1'b0;
            ALMOST_FULL <= 1'b0;
            OVERFLOW    <= 1'b0;
            RD_VALID    <= 1'b0;
            RD_DATA     <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 6'd1;
            end
            if (ld) begin
                // ram_cnt != 0 guarantees mem[rd_ptr] was written on an
                // earlier edge, so the async read never sees a word in flight.
                RD_DATA <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 6'd1;
            end
            RD_VALID    <= rd_valid_nxt;
            ram_cnt     <= ram_cnt_nxt;
            FULL        <= (ram_cnt_nxt == 7'd64);
            ALMOST_FULL <= (ram_cnt_nxt >= 7'(AF_LEVEL));
            if (WR_EN & FULL) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

`ifdef DRAM_FIFO_LEVEL_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LEVEL <= 7'd0;
        end else begin
            LEVEL <= ram_cnt_nxt + {6'd0, rd_valid_nxt};
        end
    end
`endif

endmodule

// File: tb/tb_dram_fifo64_reader.sv
module tb_dram_fifo64_reader;

  logic       CLK;
  logic       RST_N;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       FULL;
  logic       ALMOST_FULL;
  logic       OVERFLOW;
  logic       RD_VALID;
  logic       RD_READY;
  logic [7:0] RD_DATA;
`ifdef DRAM_FIFO_LEVEL_EN
  logic [6:0] LEVEL;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  dram_fifo64_reader #(.WIDTH(8), .AF_LEVEL(48)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .WR_EN       (WR_EN),
    .WR_DATA     (WR_DATA),
    .FULL        (FULL),
    .ALMOST_FULL (ALMOST_FULL),
    .OVERFLOW    (OVERFLOW),
    .RD_VALID    (RD_VALID),
    .RD_READY    (RD_READY),
    .RD_DATA     (RD_DATA)
`ifdef DRAM_FIFO_LEVEL_EN
    ,
    .LEVEL       (LEVEL)
`endif
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RST_N    = 1'b0;
    WR_EN    = 1'b0;
    WR_DATA  = 8'd0;
    RD_READY = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic write_word(input logic [7:0] d);
    WR_EN   = 1'b1;
    WR_DATA = d;
    step();
    WR_EN   = 1'b0;
  endtask

  logic [7:0] exp_w;
  int         seen;

  initial begin
    reset_dut();

    // reset state
    check("rst_valid", 32'(RD_VALID), 32'd0);
    check("rst_data", 32'(RD_DATA), 32'd0);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_af", 32'(ALMOST_FULL), 32'd0);
    check("rst_ovf", 32'(OVERFLOW), 32'd0);

    // 1: single word, held under backpressure
    write_word(8'hA5);
    check("t1_valid_edge1", 32'(RD_VALID), 32'd0);
    step();
    check("t1_valid_edge2", 32'(RD_VALID), 32'd1);
    check("t1_data_edge2", 32'(RD_DATA), 32'hA5);
    repeat (3) step();
    check("t1_valid_held", 32'(RD_VALID), 32'd1);
    check("t1_data_held", 32'(RD_DATA), 32'hA5);
    RD_READY = 1'b1;
    step();
    check("t1_valid_drained", 32'(RD_VALID), 32'd0);
    RD_READY = 1'b0;

    // 2: fill to 65 words, overflow, drain in order
    for (int i = 0; i < 64; i++) begin
      write_word(8'(i));
      exp_q.push_back(8'(i));
      if (i == 47) check("t2_af_below", 32'(ALMOST_FULL), 32'd0);
      if (i == 48) check("t2_af_at_level", 32'(ALMOST_FULL), 32'd1);
    end
    check("t2_full_after_64", 32'(FULL), 32'd0);
    check("t2_head_valid", 32'(RD_VALID), 32'd1);
    check("t2_head_data", 32'(RD_DATA), 32'd0);
    write_word(8'd64);
    exp_q.push_back(8'd64);
    check("t2_full_after_65", 32'(FULL), 32'd1);
    check("t2_ovf_clear", 32'(OVERFLOW), 32'd0);
    write_word(8'd65);
    check("t2_ovf_set", 32'(OVERFLOW), 32'd1);
    check("t2_full_still", 32'(FULL), 32'd1);
    // first drain edge also attempts a write: FULL is still 1, so it is dropped
    RD_READY = 1'b1;
    WR_EN    = 1'b1;
    WR_DATA  = 8'hEE;
    for (int k = 0; k < 65; k++) begin
      exp_w = exp_q.pop_front();
      check("t2_drain_valid", 32'(RD_VALID), 32'd1);
      check("t2_drain_data", 32'(RD_DATA), 32'(exp_w));
      step();
      WR_EN = 1'b0;
      if (k == 0) check("t2_full_drop", 32'(FULL), 32'd0);
    end
    check("t2_empty", 32'(RD_VALID), 32'd0);
    check("t2_ovf_sticky", 32'(OVERFLOW), 32'd1);

    // 3: streaming 200 words across pointer wrap
    RD_READY = 1'b1;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      WR_EN   = 1'b1;
      WR_DATA = 8'(i);
      step();
      exp_q.push_back(8'(i));
      check("t3_full", 32'(FULL), 32'd0);
      if (i == 0) check("t3_latency", 32'(RD_VALID), 32'd0);
      if (RD_VALID) begin
        exp_w = exp_q.pop_front();
        check("t3_data", 32'(RD_DATA), 32'(exp_w));
        seen++;
      end
    end
    check("t3_rate", 32'(seen), 32'd199);
    WR_EN = 1'b0;
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
      step();
      if (RD_VALID) begin
        exp_w = exp_q.pop_front();
        check("t3_tail_data", 32'(RD_DATA), 32'(exp_w));
        seen++;
      end
    end
    check("t3_total", 32'(seen), 32'd200);
    step();
    check("t3_empty", 32'(RD_VALID), 32'd0);
    RD_READY = 1'b0;

    // 5: asynchronous reset with 20 words buffered
    for (int i = 0; i < 20; i++) write_word(8'(8'hC0 + i));
    check("t5_pre_valid", 32'(RD_VALID), 32'd1);
    check("t5_pre_data", 32'(RD_DATA), 32'hC0);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check("t5_async_valid", 32'(RD_VALID), 32'd0);
    check("t5_async_data", 32'(RD_DATA), 32'd0);
    check("t5_async_ovf", 32'(OVERFLOW), 32'd0);
    check("t5_async_full", 32'(FULL), 32'd0);
    check("t5_async_af", 32'(ALMOST_FULL), 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    write_word(8'h3C);
    check("t5_post_valid0", 32'(RD_VALID), 32'd0);
    step();
    check("t5_post_valid", 32'(RD_VALID), 32'd1);
    check("t5_post_data", 32'(RD_DATA), 32'h3C);
    RD_READY = 1'b1;
    step();
    check("t5_no_stale", 32'(RD_VALID), 32'd0);
    RD_READY = 1'b0;

    // 4: almost-full threshold rise and fall
    for (int i = 0; i < 49; i++) begin
      write_word(8'(i));
      if (i == 47) check("t4_af_48w", 32'(ALMOST_FULL), 32'd0);
    end
    check("t4_af_49w", 32'(ALMOST_FULL), 32'd1);
    RD_READY = 1'b1;
    step();
    check("t4_af_fall", 32'(ALMOST_FULL), 32'd0);
    check("t4_data_after_load", 32'(RD_DATA), 32'd1);
    reset_dut();

    // 6: occupancy tracking
    write_word(8'h11);
`ifdef DRAM_FIFO_LEVEL_EN
    check("t6_level1", 32'(LEVEL), 32'd1);
`endif
    write_word(8'h22);
`ifdef DRAM_FIFO_LEVEL_EN
    check("t6_level2", 32'(LEVEL), 32'd2);
`endif
    write_word(8'h33);
`ifdef DRAM_FIFO_LEVEL_EN
    check("t6_level3", 32'(LEVEL), 32'd3);
`endif
    check("t6_head", 32'(RD_DATA), 32'h11);
    RD_READY = 1'b1;
    step();
    RD_READY = 1'b0;
`ifdef DRAM_FIFO_LEVEL_EN
    check("t6_level_read", 32'(LEVEL), 32'd2);
`endif
    check("t6_next", 32'(RD_DATA), 32'h22);
    check("t6_next_valid", 32'(RD_VALID), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
